// File: rtl/airlock_if.sv
// Airlock sequencer bus: debounced request/door inputs and registered status outputs.
interface airlock_if #(
  parameter int unsigned CNT_W = 4
);
  logic             tick;
  logic             req_fill;
  logic             req_evac;
  logic             outer_closed;
  logic             inner_closed;
  logic             pressurized;
  logic             evacuated;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             outer_unlock;
  logic             inner_unlock;
  logic             done;
  logic             reject;
  logic             fault;

  modport master (
    output tick, req_fill, req_evac, outer_closed, inner_closed,
    input  pressurized, evacuated, busy, remaining,
           outer_unlock, inner_unlock, done, reject, fault
  );

  modport slave (
    input  tick, req_fill, req_evac, outer_closed, inner_closed,
    output pressurized, evacuated, busy, remaining,
           outer_unlock, inner_unlock, done, reject, fault
  );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: arbitrates fill/evacuate, runs tick countdowns, gates door unlocks.
// Optional AIRLOCK_HOLD_EN adds a one-deep pending request for the opposite direction while busy.
module airlock_sequencer #(
  parameter int unsigned FILL_TICKS = 7,
  parameter int unsigned EVAC_TICKS = 5,
  parameter int unsigned CNT_W      = 4
) (
  input  logic     clk,
  input  logic     rst,
  airlock_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EVACUATED,
    ST_FILLING,
    ST_PRESSURIZED,
    ST_EVACUATING
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic             fault_q, fault_d;
  logic             pressurized_q, pressurized_d;
  logic             evacuated_q, evacuated_d;
  logic             busy_q, busy_d;
  logic             outer_unlock_q, outer_unlock_d;
  logic             inner_unlock_q, inner_unlock_d;
  logic             doors_ok;
  logic             filling;
  logic             fill_req;
  logic             evac_req;

`ifdef AIRLOCK_HOLD_EN
  logic             pend_q, pend_d;
`endif

  assign doors_ok = bus.outer_closed && bus.inner_closed;
  assign filling  = (state_q == ST_FILLING);

  // Next state, countdown and pulse outputs
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    fault_d  = 1'b0;
`ifdef AIRLOCK_HOLD_EN
    pend_d   = pend_q;
    // A held request is replayed in the first cycle of the new stable state
    fill_req = bus.req_fill || (pend_q && (state_q == ST_EVACUATED));
    evac_req = bus.req_evac || (pend_q && (state_q == ST_PRESSURIZED));
`else
    fill_req = bus.req_fill;
    evac_req = bus.req_evac;
`endif

    case (state_q)
      ST_EVACUATED: begin
        if (fill_req) begin
          if (doors_ok) begin
            state_d = ST_FILLING;
            rem_d   = CNT_W'(FILL_TICKS);
          end else begin
            reject_d = 1'b1;
          end
        end
        if (evac_req) reject_d = 1'b1;
`ifdef AIRLOCK_HOLD_EN
        pend_d = 1'b0;
`endif
      end

      ST_PRESSURIZED: begin
        if (evac_req) begin
          if (doors_ok) begin
            state_d = ST_EVACUATING;
            rem_d   = CNT_W'(EVAC_TICKS);
          end else begin
            reject_d = 1'b1;
          end
        end
        if (fill_req) reject_d = 1'b1;
`ifdef AIRLOCK_HOLD_EN
        pend_d = 1'b0;
`endif
      end

      ST_FILLING, ST_EVACUATING: begin
        // Door abort outranks any coincident tick, including the final one
        if (!doors_ok) begin
          state_d = filling ? ST_EVACUATED : ST_PRESSURIZED;
          rem_d   = '0;
          fault_d = 1'b1;
        end else if (bus.tick) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = filling ? ST_PRESSURIZED : ST_EVACUATED;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
`ifdef AIRLOCK_HOLD_EN
        if (filling ? bus.req_fill : bus.req_evac) reject_d = 1'b1;
        if (filling ? bus.req_evac : bus.req_fill) begin
          if (pend_q) reject_d = 1'b1;
          else        pend_d   = 1'b1;
        end
        if (!doors_ok) pend_d = 1'b0;
`else
        if (bus.req_fill || bus.req_evac) reject_d = 1'b1;
`endif
      end

      default: begin
        state_d = ST_EVACUATED;
        rem_d   = '0;
      end
    endcase

    pressurized_d  = (state_d == ST_PRESSURIZED);
    evacuated_d    = (state_d == ST_EVACUATED);
    busy_d         = (state_d == ST_FILLING) || (state_d == ST_EVACUATING);
    outer_unlock_d = (state_d == ST_EVACUATED);
    inner_unlock_d = (state_d == ST_PRESSURIZED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_EVACUATED;
      rem_q          <= '0;
      done_q         <= 1'b0;
      reject_q       <= 1'b0;
      fault_q        <= 1'b0;
      pressurized_q  <= 1'b0;
      evacuated_q    <= 1'b1;
      busy_q         <= 1'b0;
      outer_unlock_q <= 1'b1;
      inner_unlock_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      done_q         <= done_d;
      reject_q       <= reject_d;
      fault_q        <= fault_d;
      pressurized_q  <= pressurized_d;
      evacuated_q    <= evacuated_d;
      busy_q         <= busy_d;
      outer_unlock_q <= outer_unlock_d;
      inner_unlock_q <= inner_unlock_d;
    end
  end

`ifdef AIRLOCK_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end
`endif

  assign bus.pressurized  = pressurized_q;
  assign bus.evacuated    = evacuated_q;
  assign bus.busy         = busy_q;
  assign bus.remaining    = rem_q;
  assign bus.outer_unlock = outer_unlock_q;
  assign bus.inner_unlock = inner_unlock_q;
  assign bus.done         = done_q;
  assign bus.reject       = reject_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed self-checking bench for airlock_sequencer (default 7 fill / 5 evac ticks).
module tb_airlock_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  airlock_if #(.CNT_W(4)) bus ();

  airlock_sequencer #(
    .FILL_TICKS(7),
    .EVAC_TICKS(5),
    .CNT_W     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cycle();
      bus.tick = 1'b0;
    end
  endtask

  task automatic check_status(input string tag, input logic evac, input logic press,
                              input logic bsy, input logic [3:0] rem);
    check({tag, "_evacuated"},   bus.evacuated,   evac);
    check({tag, "_pressurized"}, bus.pressurized, press);
    check({tag, "_busy"},        bus.busy,        bsy);
    check({tag, "_remaining"},   bus.remaining,   rem);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.tick         = 1'b0;
    bus.req_fill     = 1'b0;
    bus.req_evac     = 1'b0;
    bus.outer_closed = 1'b1;
    bus.inner_closed = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Reset state
    check_status("reset", 1'b1, 1'b0, 1'b0, 4'd0);
    check("reset_outer_unlock", bus.outer_unlock, 1'b1);
    check("reset_inner_unlock", bus.inner_unlock, 1'b0);
    check("reset_pulses", {bus.done, bus.reject, bus.fault}, 3'b000);

    // Fill accepted with a coincident tick: load wins
    bus.req_fill = 1'b1;
    bus.tick     = 1'b1;
    cycle();
    bus.req_fill = 1'b0;
    bus.tick     = 1'b0;
    check_status("fill_start", 1'b0, 1'b0, 1'b1, 4'd7);
    check("fill_start_unlocks", {bus.outer_unlock, bus.inner_unlock}, 2'b00);
    check("fill_start_reject", bus.reject, 1'b0);

    // Countdown with idle cycles between ticks
    for (int i = 0; i < 7; i++) begin
      check("fill_rem", bus.remaining, 32'(7 - i));
      check("fill_busy", bus.busy, 1'b1);
      tick_n(1);
      if (i < 6) cycle();
    end
    check_status("fill_done", 1'b0, 1'b1, 1'b0, 4'd0);
    check("fill_done_pulse", bus.done, 1'b1);
    check("fill_done_unlocks", {bus.outer_unlock, bus.inner_unlock}, 2'b01);
    cycle();
    check("fill_done_one_cycle", bus.done, 1'b0);

    // Evac refused with inner door open
    bus.inner_closed = 1'b0;
    bus.req_evac     = 1'b1;
    cycle();
    bus.req_evac     = 1'b0;
    bus.inner_closed = 1'b1;
    check("evac_door_reject", bus.reject, 1'b1);
    check_status("evac_door_reject", 1'b0, 1'b1, 1'b0, 4'd0);
    cycle();
    check("evac_reject_one_cycle", bus.reject, 1'b0);

    // Fill refused while pressurized
    bus.req_fill = 1'b1;
    cycle();
    bus.req_fill = 1'b0;
    check("press_fill_reject", bus.reject, 1'b1);
    check("press_fill_state", bus.pressurized, 1'b1);

    // Evacuate, abort at remaining=3 with a coincident tick
    bus.req_evac = 1'b1;
    cycle();
    bus.req_evac = 1'b0;
    check_status("evac_start", 1'b0, 1'b0, 1'b1, 4'd5);
    tick_n(2);
    check("evac_rem3", bus.remaining, 4'd3);
    bus.outer_closed = 1'b0;
    bus.tick         = 1'b1;
    cycle();
    bus.tick         = 1'b0;
    check("abort_fault", bus.fault, 1'b1);
    check("abort_done", bus.done, 1'b0);
    check_status("abort", 1'b0, 1'b1, 1'b0, 4'd0);
    bus.outer_closed = 1'b1;
    cycle();
    check("abort_fault_one_cycle", bus.fault, 1'b0);

    // Full evacuation back to EVACUATED
    bus.req_evac = 1'b1;
    cycle();
    bus.req_evac = 1'b0;
    tick_n(5);
    check_status("evac_done", 1'b1, 1'b0, 1'b0, 4'd0);
    check("evac_done_pulse", bus.done, 1'b1);
    check("evac_done_unlocks", {bus.outer_unlock, bus.inner_unlock}, 2'b10);

    // Simultaneous requests: fill accepted, evac rejected
    bus.req_fill = 1'b1;
    bus.req_evac = 1'b1;
    cycle();
    bus.req_fill = 1'b0;
    bus.req_evac = 1'b0;
    check_status("simul", 1'b0, 1'b0, 1'b1, 4'd7);
    check("simul_reject", bus.reject, 1'b1);

    // Opposite request during fill at remaining=4
    tick_n(3);
    check("hold_rem4", bus.remaining, 4'd4);
    bus.req_evac = 1'b1;
    cycle();
    bus.req_evac = 1'b0;
`ifdef AIRLOCK_HOLD_EN
    check("hold_no_reject", bus.reject, 1'b0);
`else
    check("busy_evac_reject", bus.reject, 1'b1);
`endif
    check("hold_busy", bus.busy, 1'b1);
    tick_n(4);
    check_status("hold_press", 1'b0, 1'b1, 1'b0, 4'd0);
    check("hold_press_done", bus.done, 1'b1);
    cycle();
`ifdef AIRLOCK_HOLD_EN
    check_status("hold_evac", 1'b0, 1'b0, 1'b1, 4'd5);
`else
    check_status("nohold_stay", 1'b0, 1'b1, 1'b0, 4'd0);
    bus.req_evac = 1'b1;
    cycle();
    bus.req_evac = 1'b0;
`endif
    // Redundant request during evacuation is refused
    bus.req_evac = 1'b1;
    cycle();
    bus.req_evac = 1'b0;
    check("redundant_reject", bus.reject, 1'b1);
    check("redundant_rem", bus.remaining, 4'd5);
    tick_n(5);
    check_status("back_evac", 1'b1, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset during fill at remaining=2
    bus.req_fill = 1'b1;
    cycle();
    bus.req_fill = 1'b0;
    tick_n(5);
    check("rst_rem2", bus.remaining, 4'd2);
    #2 rst = 1'b1;
    #1;
    check_status("async_rst", 1'b1, 1'b0, 1'b0, 4'd0);
    check("async_rst_outer_unlock", bus.outer_unlock, 1'b1);
    rst = 1'b0;
    tick_n(1);
    check_status("post_rst_tick", 1'b1, 1'b0, 1'b0, 4'd0);
    check("post_rst_done", bus.done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
